// File: rtl/spi_double_buffer.sv
// Ping-pong word buffer between the NITTA-side writer and the SPI-side reader.
// The writer fills bank `bank_sel` while the reader drains bank `~bank_sel`.
// A `swap` strobe exchanges the two banks at a transfer boundary.
//
// Strobe semantics: `wr`, `oe` and `swap` are level-sampled once per rising
// edge, and each high cycle counts as one event. There is no back-pressure.
//   - A write while `wr_full` is dropped and raises `overflow`.
//   - A read while `rd_empty` is ignored and raises `underflow`.
//   - `data_out` shows the current read word combinationally (first-word
//     fall-through). `oe` consumes that word at the edge.
module spi_double_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_SIZE   = 8,
  parameter int ADDR_WIDTH = $clog2(BUF_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  swap,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  oe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  wr_full,
  output logic                  rd_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(BUF_SIZE);

  // Two banks stored flat; the bank select bit is the top address bit.
  logic [DATA_WIDTH-1:0] mem [0:2*BUF_SIZE-1];

  logic                bank_sel;
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] rd_len;
  logic                wr_en;
  logic                rd_en;

  assign wr_full  = (wr_ptr == FULL_COUNT);
  assign rd_empty = (rd_ptr == rd_len);
  assign wr_count = wr_ptr;
  assign rd_count = rd_len - rd_ptr;

  // A write is accepted whenever there is room, including on a swap edge.
  // In that case it lands in the outgoing bank.
  assign wr_en = wr && !wr_full && !rst;
  // A swap takes precedence over a read in the same cycle.
  assign rd_en = oe && !rd_empty && !swap;

  // Memory write port; contents are never reset, and the data_out mask hides stale words.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{bank_sel, wr_ptr[ADDR_WIDTH-1:0]}] <= data_in;
    end
  end

  // Read word, masked to zero while the read bank has nothing unread.
  always_comb begin
    data_out = '0;
    if (!rd_empty) begin
      data_out = mem[{~bank_sel, rd_ptr[ADDR_WIDTH-1:0]}];
    end
  end

  // Bank select, pointers, read length and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_len    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && wr_full) begin
        overflow <= 1'b1;
      end
      if (swap) begin
        // Any unread words in the old read bank are discarded without error.
        bank_sel <= ~bank_sel;
        rd_len   <= wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_en};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (rd_en) begin
          rd_ptr <= rd_ptr + 1'b1;
        end else if (oe) begin
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_double_buffer.sv
// Bench for spi_double_buffer (DATA_WIDTH=8, BUF_SIZE=4).
// It runs the directed test plan steps, followed by random strobe traffic.
// A reference model holds the two banks as word queues.
module tb_spi_double_buffer;

  localparam int DW  = 8;
  localparam int BSZ = 4;
  localparam int AW  = $clog2(BSZ);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          swap = 1'b0;
  logic          wr = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          oe = 1'b0;
  logic [DW-1:0] data_out;
  logic [AW:0]   wr_count;
  logic [AW:0]   rd_count;
  logic          wr_full;
  logic          rd_empty;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int failures = 0;

  // Reference model: the write bank and the unread part of the read bank as queues.
  logic [DW-1:0] wq[$];
  logic [DW-1:0] rq[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;

  spi_double_buffer #(.DATA_WIDTH(DW), .BUF_SIZE(BSZ)) dut (
    .clk(clk), .rst(rst), .swap(swap), .wr(wr), .data_in(data_in), .oe(oe),
    .data_out(data_out), .wr_count(wr_count), .rd_count(rd_count),
    .wr_full(wr_full), .rd_empty(rd_empty), .overflow(overflow), .underflow(underflow)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the buffer's rules, applied to whole queues.
  task automatic model_step(input logic r, input logic s, input logic w,
                            input logic [DW-1:0] d, input logic o);
    if (r) begin
      wq.delete(); rq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (w) begin
        if (wq.size() < BSZ) wq.push_back(d);
        else m_ovf = 1'b1;
      end
      if (s) begin
        rq = wq;
        wq.delete();
      end else if (o) begin
        if (rq.size() > 0) void'(rq.pop_front());
        else m_unf = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] exp_d;
    exp_d = (rq.size() > 0) ? rq[0] : '0;
    chk({tag, ".data_out"}, 32'(data_out), 32'(exp_d));
    chk({tag, ".wr_count"}, 32'(wr_count), 32'(wq.size()));
    chk({tag, ".rd_count"}, 32'(rd_count), 32'(rq.size()));
    chk({tag, ".wr_full"}, 32'(wr_full), 32'(wq.size() == BSZ));
    chk({tag, ".rd_empty"}, 32'(rd_empty), 32'(rq.size() == 0));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // Driver: apply one cycle of strobes, step the model, then check 1 time unit after the edge.
  task automatic cyc(input logic r, input logic s, input logic w,
                     input logic [DW-1:0] d, input logic o, input string tag);
    rst = r; swap = s; wr = w; data_in = d; oe = o;
    @(posedge clk);
    model_step(r, s, w, d, o);
    #1;
    check_all(tag);
    rst = 1'b0; swap = 1'b0; wr = 1'b0; oe = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, tag);
  endtask

  initial begin
    logic r, s, w, o;
    logic [DW-1:0] d;

    // 1. Reset with stray strobes.
    cyc(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1, "reset");
    chk("reset.data_out_zero", 32'(data_out), 32'h0);
    chk("reset.rd_empty_one", 32'(rd_empty), 32'h1);

    // 2. Basic transfer, writes spaced 9 cycles apart.
    cyc(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, "t2.wr"); idle(8, "t2.gap");
    cyc(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, "t2.wr"); idle(8, "t2.gap");
    cyc(1'b0, 1'b0, 1'b1, 8'h33, 1'b0, "t2.wr");
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, "t2.swap");
    chk("t2.rd_count3", 32'(rd_count), 32'd3);
    chk("t2.first11", 32'(data_out), 32'h11);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, "t2.oe");
    chk("t2.word22", 32'(data_out), 32'h22);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, "t2.oe");
    chk("t2.word33", 32'(data_out), 32'h33);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, "t2.oe");
    chk("t2.drained", 32'({rd_empty, data_out}), 32'h100);

    // 3. Overflow.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0, "t3.wr");
      if (i == 3) chk("t3.full_after_a3", 32'(wr_full), 32'h1);
    end
    chk("t3.overflow", 32'(overflow), 32'h1);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, "t3.swap");
    chk("t3.rd_count4", 32'(rd_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t3.read", 32'(data_out), 32'hA0 + i);
      cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, "t3.oe");
    end

    // 4. Write coinciding with swap.
    cyc(1'b0, 1'b0, 1'b1, 8'h44, 1'b0, "t4.wr");
    cyc(1'b0, 1'b1, 1'b1, 8'h55, 1'b0, "t4.wrswap");
    chk("t4.rd_count2", 32'(rd_count), 32'd2);
    chk("t4.wr_count0", 32'(wr_count), 32'd0);
    chk("t4.first44", 32'(data_out), 32'h44);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, "t4.oe");
    chk("t4.second55", 32'(data_out), 32'h55);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, "t4.oe");

    // 5. Ping-pong: writes alongside reads.
    cyc(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, "t5.wr");
    cyc(1'b0, 1'b0, 1'b1, 8'h02, 1'b0, "t5.wr");
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, "t5.swap");
    chk("t5.read01", 32'(data_out), 32'h01);
    cyc(1'b0, 1'b0, 1'b1, 8'h77, 1'b1, "t5.wroe");
    chk("t5.read02", 32'(data_out), 32'h02);
    cyc(1'b0, 1'b0, 1'b1, 8'h88, 1'b1, "t5.wroe");
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, "t5.swap2");
    chk("t5.read77", 32'(data_out), 32'h77);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, "t5.oe");
    chk("t5.read88", 32'(data_out), 32'h88);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, "t5.oe");

    // 6. Underflow, then reset in the middle of filling a bank.
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, "t6.oe_empty");
    chk("t6.underflow", 32'(underflow), 32'h1);
    chk("t6.rd_count0", 32'(rd_count), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0, "t6.wr");
    cyc(1'b0, 1'b0, 1'b1, 8'hC2, 1'b0, "t6.wr");
    cyc(1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, "t6.rst");
    chk("t6.reset_clean", 32'({underflow, overflow, wr_count, rd_count}), 32'h0);

    // Random strobe traffic against the model.
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 6) == 0);
      w = ($urandom_range(0, 1) == 1);
      o = ($urandom_range(0, 1) == 1);
      d = 8'($urandom);
      cyc(r, s, w, d, o, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_double_buffer.md
# spi_double_buffer

Parametrised ping-pong data buffer for the SPI slave processing unit. It generalises the single-bank `spi_buffer` to a configurable word width and depth, with two banks. The NITTA-side writer fills one bank while the SPI-side reader drains the other, and a `swap` strobe exchanges them at a transfer boundary. It also adds occupancy counters, full/empty flags and sticky overflow/underflow error flags.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width in bits.
- `BUF_SIZE`, 8, words per bank; power of two, at least 2.
- `ADDR_WIDTH`, `$clog2(BUF_SIZE)`, pointer width; derived, not overridden.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `swap`  in  1  exchange write and read banks at this edge.
- `wr`  in  1  write `data_in` into the write bank.
- `data_in`  in  DATA_WIDTH  word to store.
- `oe`  in  1  consume the current read word and advance the read pointer.
- `data_out`  out  DATA_WIDTH  current read word; 0 when `rd_empty`.
- `wr_count`  out  ADDR_WIDTH+1  words held in the write bank.
- `rd_count`  out  ADDR_WIDTH+1  unread words remaining in the read bank.
- `wr_full`  out  1  `wr_count == BUF_SIZE`.
- `rd_empty`  out  1  `rd_count == 0`.
- `overflow`  out  1  sticky; a write was attempted while full.
- `underflow`  out  1  sticky; a read was attempted while empty.

## Operation
- State registers:
  - `bank_sel`: write bank = `bank_sel`, read bank = `~bank_sel`.
  - `wr_ptr`.
  - `rd_ptr`.
  - `rd_len`: number of valid words in the read bank.
  - `overflow` and `underflow` flags.
- Memory is 2×BUF_SIZE words and is not cleared by reset. Stale contents are never visible because `data_out` is masked while empty.
- Write: on `wr && !wr_full`, store `mem[bank_sel][wr_ptr] <= data_in` and increment `wr_ptr`.
  - On `wr && wr_full`, drop the word and set `overflow <= 1`.
- Read: `data_out` is combinational from registered state.
  - When `rd_empty`, `data_out = 0`; otherwise `data_out = mem[~bank_sel][rd_ptr]`.
  - On `oe && !rd_empty`, increment `rd_ptr`.
  - On `oe && rd_empty`, set `underflow <= 1` and leave the pointer unchanged.
- `rd_count = rd_len - rd_ptr` and `wr_count = wr_ptr`. Counters never wrap: pointers saturate at BUF_SIZE via the full/empty guards.
- Swap (`swap == 1`):
  - Toggle `bank_sel`.
  - Set `rd_len <= wr_ptr + (wr && !wr_full)`.
  - Set `rd_ptr <= 0` and `wr_ptr <= 0`.
  - Unread words in the old read bank are discarded silently; this is not an error.
- Simultaneous `wr` and `swap`: the write lands in the outgoing write bank first and is included in the new `rd_len`. Overflow rules still apply.
- Simultaneous `oe` and `swap`: swap wins. `oe` has no effect and does not set `underflow`.
- Simultaneous `wr` and `oe` without `swap`: both act independently, because they target different banks.
- Error flags are cleared only by `rst`.

## Timing
- Reset values:
  - `bank_sel = 0`, all pointers 0 and `rd_len = 0`.
  - `data_out = 0`, `wr_count = 0`, `rd_count = 0`.
  - `wr_full = 0`, `rd_empty = 1`, `overflow = 0`, `underflow = 0`.
- `rst` has priority over `swap`, `wr` and `oe` in the same cycle, including mid-transfer. Any partial bank content is abandoned.
- Write latency: `wr_count` and `wr_full` update at the edge sampling `wr`. The data is not readable until after a swap.
- Swap latency: the first word appears on `data_out` immediately after the swap edge, with zero read latency (first-word fall-through).
- `oe` advances the read word at the same edge. The next word is valid right after that edge, so back-to-back `oe` on consecutive cycles is supported.
- All strobes are level-sampled per cycle. A strobe held high for N cycles counts as N events.

## Test plan
Use `DATA_WIDTH = 8`, `BUF_SIZE = 4`, and a 10-time-unit clock, as in the existing SPI bench.

1. **Reset:** assert `rst` for 1 cycle with stray `wr`/`oe` asserted.
   - Expect `data_out = 0`, `rd_empty = 1`, `wr_count = 0`, `rd_count = 0` and both error flags 0.
2. **Basic transfer:** `wr` 0x11, 0x22, 0x33 (one pulse every 9 cycles), then `swap`.
   - After the swap: `rd_count = 3`, `data_out = 0x11`.
   - Three `oe` pulses step `data_out` through 0x22, 0x33, then 0 with `rd_empty = 1`.
3. **Overflow:** `wr` 0xA0 through 0xA4.
   - `wr_full = 1` after 0xA3; 0xA4 is dropped and `overflow = 1`.
   - After `swap`: reads give 0xA0 through 0xA3 and `rd_count` starts at 4.
4. **Simultaneous write and swap:** `wr` 0x44, then `wr` 0x55 in the same cycle as `swap`.
   - Expect `rd_count = 2`, reads 0x44 then 0x55, and `wr_count = 0`.
5. **Ping-pong:** while draining bank data 0x01, 0x02, interleave `wr` 0x77, 0x88 on the same cycles as `oe`.
   - Reads are 0x01, 0x02 and unaffected by the writes.
   - The next `swap` exposes 0x77, 0x88.
6. **Underflow and mid-operation reset:** pulse `oe` while `rd_empty`.
   - Expect `underflow = 1` and `rd_count` stays 0.
   - Then write 2 words and assert `rst`: all outputs return to reset values and `underflow = 0`.
